// File: rtl/decode_regfile_pipe.sv
// Y86-64 decode/writeback stage: register file, operand selection and D->E pipeline register.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data to the srcA/srcB/dbg reads.
module decode_regfile_pipe #(
  parameter int W       = 64,
  parameter int NREG    = 15,
  parameter int RSP_IDX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d_valid_i,
  input  logic [3:0]   d_icode_i,
  input  logic [3:0]   d_rA_i,
  input  logic [3:0]   d_rB_i,
  input  logic [3:0]   d_dstE_i,
  input  logic [3:0]   d_dstM_i,
  input  logic [W-1:0] d_valC_i,
  input  logic [W-1:0] d_valP_i,
  input  logic         stall_i,
  input  logic         bubble_i,
  input  logic [3:0]   w_dstE_i,
  input  logic [W-1:0] w_valE_i,
  input  logic [3:0]   w_dstM_i,
  input  logic [W-1:0] w_valM_i,
  output logic         e_valid_o,
  output logic [3:0]   e_icode_o,
  output logic [W-1:0] e_valA_o,
  output logic [W-1:0] e_valB_o,
  output logic [W-1:0] e_valC_o,
  output logic [3:0]   e_srcA_o,
  output logic [3:0]   e_srcB_o,
  output logic [3:0]   e_dstE_o,
  output logic [3:0]   e_dstM_o,
  input  logic [3:0]   dbg_sel_i,
  output logic [W-1:0] dbg_val_o
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] RSP     = 4'(RSP_IDX);

  logic [W-1:0] regs_reg [NREG];
  logic [W-1:0] rf_view  [16];
  logic         we_act, wm_act;

  assign we_act = !rst && (w_dstE_i != RNONE) && (int'(w_dstE_i) < NREG);
  assign wm_act = !rst && (w_dstM_i != RNONE) && (int'(w_dstM_i) < NREG);

  // Port M is checked first so it wins a same-index conflict.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)
          regs_reg[gi] <= '0;
        else if (wm_act && (w_dstM_i == 4'(gi)))
          regs_reg[gi] <= w_valM_i;
        else if (we_act && (w_dstE_i == 4'(gi)))
          regs_reg[gi] <= w_valE_i;
      end
    end
    // Full 16-entry view so unimplemented indices (incl. RNONE) read as zero.
    for (gi = 0; gi < 16; gi++) begin : g_view
      if (gi < NREG) begin : g_impl
        assign rf_view[gi] = regs_reg[gi];
      end else begin : g_none
        assign rf_view[gi] = '0;
      end
    end
  endgenerate

  function automatic logic [W-1:0] rd(input logic [3:0] idx);
    logic [W-1:0] v;
    v = rf_view[idx];
`ifdef DECODE_BYPASS_EN
    if (wm_act && (w_dstM_i == idx))
      v = w_valM_i;
    else if (we_act && (w_dstE_i == idx))
      v = w_valE_i;
`endif
    return v;
  endfunction

  logic [3:0]   src_a, src_b;
  logic [W-1:0] val_a, val_b;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    case (d_icode_i)
      I_RRMOV, I_RMMOV, I_OPQ, I_PUSH: src_a = d_rA_i;
      I_POP, I_RET:                    src_a = RSP;
      default:                         src_a = RNONE;
    endcase
    case (d_icode_i)
      I_OPQ, I_RMMOV, I_MRMOV:         src_b = d_rB_i;
      I_PUSH, I_POP, I_CALL, I_RET:    src_b = RSP;
      default:                         src_b = RNONE;
    endcase
  end

  always_comb begin
    val_a = rd(src_a);
    if ((d_icode_i == I_CALL) || (d_icode_i == I_JXX))
      val_a = d_valP_i;
    val_b = rd(src_b);
  end

  assign dbg_val_o = rd(dbg_sel_i);

  logic         e_valid_reg;
  logic [3:0]   e_icode_reg, e_srca_reg, e_srcb_reg, e_dste_reg, e_dstm_reg;
  logic [W-1:0] e_vala_reg, e_valb_reg, e_valc_reg;

  // Priority: reset, then stall (hold), then bubble or invalid D, then load.
  always_ff @(posedge clk) begin
    if (rst || (!stall_i && (bubble_i || !d_valid_i))) begin
      e_valid_reg <= 1'b0;
      e_icode_reg <= I_NOP;
      e_vala_reg  <= '0;
      e_valb_reg  <= '0;
      e_valc_reg  <= '0;
      e_srca_reg  <= RNONE;
      e_srcb_reg  <= RNONE;
      e_dste_reg  <= RNONE;
      e_dstm_reg  <= RNONE;
    end else if (!stall_i) begin
      e_valid_reg <= 1'b1;
      e_icode_reg <= d_icode_i;
      e_vala_reg  <= val_a;
      e_valb_reg  <= val_b;
      e_valc_reg  <= d_valC_i;
      e_srca_reg  <= src_a;
      e_srcb_reg  <= src_b;
      e_dste_reg  <= d_dstE_i;
      e_dstm_reg  <= d_dstM_i;
    end
  end

  assign e_valid_o = e_valid_reg;
  assign e_icode_o = e_icode_reg;
  assign e_valA_o  = e_vala_reg;
  assign e_valB_o  = e_valb_reg;
  assign e_valC_o  = e_valc_reg;
  assign e_srcA_o  = e_srca_reg;
  assign e_srcB_o  = e_srcb_reg;
  assign e_dstE_o  = e_dste_reg;
  assign e_dstM_o  = e_dstm_reg;

endmodule

// File: doc/decode_regfile_pipe.md
# decode_regfile_pipe

Parametrised decode/writeback stage for the Y86-64 processor: it holds the architectural register file, selects source operands from the fetched instruction, and registers the decoded bundle into a D→E pipeline register with stall/bubble control. It is the pipelined successor to the combinational sequential-core `decode`. It sits between `fetch` (icode, rA, rB, dstE, dstM, valC, valP) and the execute stage, and takes its writeback inputs from the W stage.

## Interface
Parameters:
- `W` — default 64 — data width of registers and values.
- `NREG` — default 15 — implemented registers, indices 0..NREG-1. Index 15 (`RNONE`) is never implemented.
- `RSP_IDX` — default 4 — stack-pointer index.

Ports:
- `clk` in 1 — the block's only clock.
- `rst` in 1 — reset; synchronous, active-high.
- `d_valid_i` in 1 — D-stage instruction valid.
- `d_icode_i` / `d_rA_i` / `d_rB_i` in 4 each — from fetch.
- `d_dstE_i` / `d_dstM_i` in 4 each — destinations from fetch.
- `d_valC_i` / `d_valP_i` in W each — constant and next PC.
- `stall_i` in 1 — hold the E register.
- `bubble_i` in 1 — load a NOP into the E register.
- `w_dstE_i` in 4, `w_valE_i` in W — writeback port E.
- `w_dstM_i` in 4, `w_valM_i` in W — writeback port M.
- `e_valid_o` in→out 1, `e_icode_o` out 4 — registered valid and icode.
- `e_valA_o` / `e_valB_o` / `e_valC_o` out W each — registered operands.
- `e_srcA_o` / `e_srcB_o` / `e_dstE_o` / `e_dstM_o` out 4 each — registered register IDs.
- `dbg_sel_i` in 4, `dbg_val_o` out W — combinational debug read. Returns 0 for 15 or ≥NREG.

## Operation
- **srcA:**
  - rrmovq(2), rmmovq(4), opq(6), pushq(A) → rA.
  - popq(B), ret(9) → RSP_IDX.
  - Otherwise 15.
- **srcB:**
  - opq, rmmovq, mrmovq(5) → rB.
  - pushq, popq, call(8), ret → RSP_IDX.
  - Otherwise 15.
- **valA:** call and jXX(7) use d_valP_i. Otherwise valA = read(srcA).
- **valB:** valB = read(srcB).
- **Register reads:**
  - Reading index 15 or ≥NREG returns 0.
  - Reads are combinational from the array, subject to the bypass described under Configuration.
- **Writeback:**
  - On each rising edge with rst=0, port E writes when `w_dstE_i`≠15 and <NREG.
  - Port M writes under the same condition.
  - Out-of-range indices are dropped silently.
  - If both ports target the same index, M wins.
- **E register update, priority `rst` > `stall_i` > `bubble_i` > load:**
  - Bubble/reset value: valid=0, icode=1 (NOP), src/dst=15, valA/valB/valC=0.
  - Stall: all E outputs hold their values.
  - Load: captures valid, icode, valA, valB, valC, srcA, srcB, dstE, dstM.
  - When d_valid_i=0 on a load, a bubble is loaded.

## Timing
- Latency is 1 cycle from D inputs to E outputs.
- Register-file writes are visible to combinational reads after the edge. Same-cycle visibility depends on `DECODE_BYPASS_EN`.
- Reset:
  - All NREG registers clear to 0 on the reset edge.
  - E outputs take the bubble value.
  - Writeback inputs are ignored during the reset cycle.
- Reset asserted mid-stall still clears; a stall does not block reset.
- stall_i and bubble_i high together: stall wins, no bubble is inserted.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A read whose index equals an active `w_dstM_i` returns `w_valM_i`.
  - Otherwise, a read matching `w_dstE_i` returns `w_valE_i`.
  - Otherwise the read returns the array value.
  - This gives write-before-read semantics in a single cycle. It applies to the srcA, srcB and dbg reads.
- Undefined: reads return the array value only. A same-cycle write becomes visible on the next cycle.

## Test plan
- **Reset:** rst=1 for 1 cycle → e_icode_o=1, e_valid_o=0, e_dstE_o=15. dbg_val_o=0 for every index 0..14.
- **Writeback and opq:**
  - Write w_dstE_i=2, w_valE_i=7. Next cycle write w_dstE_i=3, w_valE_i=5.
  - Then issue opq with rA=2, rB=3, dstE=3 → one cycle later e_valA_o=7, e_valB_o=5, e_srcA_o=2, e_srcB_o=3.
- **pushq / call:**
  - Set reg 4 = 0x100. Issue pushq rA=0 (reg0=9) → e_valA_o=9, e_valB_o=0x100.
  - Issue call with valP=0x2A → e_valA_o=0x2A, e_srcA_o=15.
- **Dual write conflict:** w_dstE_i=w_dstM_i=5, valE=1, valM=2 → next cycle dbg_sel_i=5 gives 2.
- **Stall/bubble:**
  - Load opq, then stall_i=1 for 2 cycles while D changes → E outputs unchanged.
  - Then stall_i=bubble_i=1 → still held.
  - Then bubble_i=1 alone → e_icode_o=1, e_valid_o=0.
- **Bypass:** in the same cycle, write reg 6=0xAB and decode rrmovq rA=6 → e_valA_o=0xAB with `DECODE_BYPASS_EN`, old value (0) without it.
